// File: rtl/mux_nto1_pipe.sv
// N-way WIDTH-bit select with one registered stage and a 2-entry skid buffer (valid/ready).
// Define MUX_ERR_CNT_EN to add the saturating 8-bit out-of-range select counter port err_cnt.
module mux_nto1_pipe #(
   parameter int unsigned      WIDTH   = 32,
   parameter int unsigned      N       = 4,
   parameter int unsigned      SEL_W   = 2,
   parameter logic [WIDTH-1:0] DEFAULT = '0
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_sel_err,
   output logic               out_valid,
   input  logic               out_ready
`ifdef MUX_ERR_CNT_EN
   ,
   output logic [7:0]         err_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] head_data, skid_data, sel_word;
   logic             head_err, skid_err, sel_err;
   logic             accept, consume;
   logic             load_head_new, load_head_skid, load_skid;

   always_comb begin
      sel_word = DEFAULT;
      sel_err  = 1'b1;
      for (int unsigned k = 0; k < N; k++) begin
         if (32'(in_sel) == k) begin
            sel_word = in_data[k*WIDTH +: WIDTH];
            sel_err  = 1'b0;
         end
      end
   end

   // Handshake outputs decode the state register only, so in_ready never sees out_ready.
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt     = ONE;
               load_head_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_head_new = 1'b1;
            end else if (accept) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end else if (consume) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (consume) begin
               state_nxt      = ONE;
               load_head_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         head_data <= '0;
         head_err  <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
      end else begin
         if (load_head_new) begin
            head_data <= sel_word;
            head_err  <= sel_err;
         end else if (load_head_skid) begin
            head_data <= skid_data;
            head_err  <= skid_err;
         end
         if (load_skid) begin
            skid_data <= sel_word;
            skid_err  <= sel_err;
         end
      end
   end

   assign out_data    = head_data;
   assign out_sel_err = head_err;

`ifdef MUX_ERR_CNT_EN
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)                                   err_cnt <= '0;
      else if (accept && sel_err && err_cnt != '1)  err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: N=4 and N=3/DEADBEEF instances share stimulus; scoreboard queues
// hold expected words pushed on accept and popped on consume.
module tb_mux_nto1_pipe;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic [31:0]   din [4];
   logic [1:0]    in_sel;
   logic          in_valid, out_ready;
   logic          a_in_ready, a_out_valid, a_out_sel_err;
   logic          b_in_ready, b_out_valid, b_out_sel_err;
   logic [31:0]   a_out_data, b_out_data;
   logic [127:0]  a_in_data;
   logic [95:0]   b_in_data;
`ifdef MUX_ERR_CNT_EN
   logic [7:0]    a_err_cnt, b_err_cnt;
   int            errcnt_model = 0;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [32:0]   qa[$];
   logic [32:0]   qb[$];

   assign a_in_data = {din[3], din[2], din[1], din[0]};
   assign b_in_data = {din[2], din[1], din[0]};

   always #5 Clk = ~Clk;

   mux_nto1_pipe #(.WIDTH(32), .N(4), .SEL_W(2), .DEFAULT(32'h0)) dut_a (
      .Clk(Clk), .Rst_n(Rst_n), .in_data(a_in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_sel_err(a_out_sel_err),
      .out_valid(a_out_valid), .out_ready(out_ready)
`ifdef MUX_ERR_CNT_EN
      , .err_cnt(a_err_cnt)
`endif
   );

   mux_nto1_pipe #(.WIDTH(32), .N(3), .SEL_W(2), .DEFAULT(32'hDEADBEEF)) dut_b (
      .Clk(Clk), .Rst_n(Rst_n), .in_data(b_in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_sel_err(b_out_sel_err),
      .out_valid(b_out_valid), .out_ready(out_ready)
`ifdef MUX_ERR_CNT_EN
      , .err_cnt(b_err_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [32:0] exp_a(input logic [1:0] s);
      return {1'b0, din[s]};
   endfunction

   function automatic logic [32:0] exp_b(input logic [1:0] s);
      return (s < 2'd3) ? {1'b0, din[s]} : {1'b1, 32'hDEADBEEF};
   endfunction

   // Model occupancy is the queue depth; consume is judged before accept of the same edge.
   always @(negedge Clk) begin
      bit          acc, con;
      logic [32:0] e;
      if (Rst_n) begin
         acc = in_valid && (qa.size() < 2);
         con = out_ready && (qa.size() > 0);
         check("a_in_ready",  a_in_ready,  qa.size() < 2);
         check("b_in_ready",  b_in_ready,  qb.size() < 2);
         check("a_out_valid", a_out_valid, qa.size() > 0);
         check("b_out_valid", b_out_valid, qb.size() > 0);
`ifdef MUX_ERR_CNT_EN
         check("a_err_cnt", a_err_cnt, 0);
         check("b_err_cnt", b_err_cnt, errcnt_model);
`endif
         if (con && qa.size() > 0) begin
            e = qa.pop_front();
            check("a_data", a_out_data, e[31:0]);
            check("a_err",  a_out_sel_err, e[32]);
            e = qb.pop_front();
            check("b_data", b_out_data, e[31:0]);
            check("b_err",  b_out_sel_err, e[32]);
         end
         if (acc) begin
            qa.push_back(exp_a(in_sel));
            qb.push_back(exp_b(in_sel));
`ifdef MUX_ERR_CNT_EN
            if (in_sel == 2'd3 && errcnt_model < 255) errcnt_model++;
`endif
         end
      end
   end

   initial begin
      Rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_sel = '0;
      foreach (din[i]) din[i] = '0;
      repeat (2) step();
      check("rst_in_ready",  a_in_ready, 1);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data",  a_out_data, 0);
      check("rst_out_err",   b_out_sel_err, 0);
      Rst_n = 1'b1;
      step();

      // Streaming through all four inputs
      din[0] = 32'h11111111; din[1] = 32'h22222222; din[2] = 32'h33333333; din[3] = 32'h44444444;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_sel = 2'(i);
         step();
         check("stream_latency", a_out_data, din[i]);
         check("stream_in_ready", a_in_ready, 1);
      end
      in_valid = 1'b0;
      repeat (2) step();

      // Backpressure fills the skid buffer
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd1;
      step();
      in_sel = 2'd2;
      step();
      check("bp_in_ready_low", a_in_ready, 0);
      check("bp_hold_data", a_out_data, 32'h22222222);
      in_sel = 2'd3;
      repeat (2) step();
      check("bp_still_hold", a_out_data, 32'h22222222);
      check("bp_still_full", a_in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_second_word", a_out_data, 32'h33333333);
      check("bp_in_ready_back", a_in_ready, 1);
      step();
      check("bp_drained", a_out_valid, 0);
      check("bp_retain_data", a_out_data, 32'h33333333);

      // Out-of-range select on the N=3 instance
      in_valid = 1'b1;
      in_sel = 2'd3;
      step();
      check("oor_data", b_out_data, 32'hDEADBEEF);
      check("oor_err", b_out_sel_err, 1);
      check("oor_a_data", a_out_data, 32'h44444444);
      in_sel = 2'd0;
      step();
      check("oor_next_err", b_out_sel_err, 0);
      check("oor_next_data", b_out_data, 32'h11111111);
      in_valid = 1'b0;
      step();

      // Alternating valid with out_ready=1 never fills the skid
      for (int i = 0; i < 200; i++) begin
         in_valid = (i % 2 == 0);
         if (in_valid) begin
            foreach (din[k]) din[k] = $urandom;
            in_sel = 2'($urandom_range(0, 3));
         end
         step();
         check("alt_in_ready", a_in_ready, 1);
      end

      // Random valid/ready
      for (int i = 0; i < 200; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         foreach (din[k]) din[k] = $urandom;
         in_sel = 2'($urandom_range(0, 3));
         step();
      end

`ifdef MUX_ERR_CNT_EN
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_sel = 2'd3;
      repeat (300) step();
      in_valid = 1'b0;
      step();
      check("err_cnt_sat", b_err_cnt, 8'hFF);
`endif

      // Reset mid-cycle with two words held
      in_valid = 1'b1;
      out_ready = 1'b0;
      din[1] = 32'hCAFEF00D;
      in_sel = 2'd1;
      step();
      in_sel = 2'd2;
      step();
      in_valid = 1'b0;
      #2;
      Rst_n = 1'b0;
      qa.delete();
      qb.delete();
`ifdef MUX_ERR_CNT_EN
      errcnt_model = 0;
`endif
      #1;
      check("midrst_out_valid", a_out_valid, 0);
      check("midrst_in_ready", a_in_ready, 1);
      check("midrst_out_data", a_out_data, 0);
      check("midrst_b_err", b_out_sel_err, 0);
`ifdef MUX_ERR_CNT_EN
      check("midrst_err_cnt", b_err_cnt, 0);
`endif
      step();
      Rst_n = 1'b1;
      step();
      din[0] = 32'hA5A5A5A5;
      in_sel = 2'd0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("post_rst_data", a_out_data, 32'hA5A5A5A5);
      check("post_rst_valid", a_out_valid, 1);

      for (int i = 0; i < 10 && qa.size() != 0; i++) step();
      check("drain_empty", qa.size(), 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
